// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like memory port between instruction
// fetch (inst) and data access (data). Grants one master at a time, holds
// the grant until the slave takes the address, and keeps an in-order tag
// FIFO so each response is routed back to the master that issued it.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant held; arbitration is combinational this cycle
//   HOLD  | grant latched in grant_q (0 = inst, 1 = data), waiting for
//         | mem_addr_ok; the other master is ignored
module sram_port_arbiter #(
  parameter int MAX_OUT   = 2,
  parameter int DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [2:0]  outstanding,
  output logic        err_rsp
);

  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUT);
  localparam logic [1:0] PTR_LAST = 2'(MAX_OUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q;
  logic        grant_q;
  logic        last_q;
  logic        tag_q [4];
  logic [1:0]  head_q;
  logic [1:0]  tail_q;
  logic [2:0]  count_q;
  logic        err_q;

  logic        sel;
  logic        owner;
  logic        owner_req;
  logic        not_full;
  logic        req_int;
  logic        accept;
  logic        rsp_valid;
  logic        rsp_tag;

  // Pointers wrap at MAX_OUT, which need not be a power of two.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Arbitration among fresh requests; only meaningful while IDLE.
  always_comb begin
    sel = 1'b0;
    if (inst_req && !data_req) begin
      sel = 1'b0;
    end else if (data_req && !inst_req) begin
      sel = 1'b1;
    end else if (inst_req && data_req) begin
      sel = (DATA_PRIO != 0) ? 1'b1 : ~last_q;
    end
  end

  // Port ownership, flow control against the tag FIFO, accept/response qualification.
  always_comb begin
    owner     = (state_q == HOLD) ? grant_q : sel;
    owner_req = owner ? data_req : inst_req;
    not_full  = (count_q < MAX_CNT);
    req_int   = owner_req & not_full;
    accept    = req_int & mem_addr_ok;
    rsp_valid = mem_data_ok & (count_q != 3'd0);
    rsp_tag   = tag_q[head_q];
  end

  // Shared-port fields follow the owner; everything is forced low in reset.
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_wstrb    = 4'd0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_rdata   = 32'd0;
    if (!rst) begin
      mem_req      = req_int;
      mem_wr       = owner ? data_wr    : inst_wr;
      mem_size     = owner ? data_size  : inst_size;
      mem_wstrb    = owner ? data_wstrb : inst_wstrb;
      mem_addr     = owner ? data_addr  : inst_addr;
      mem_wdata    = owner ? data_wdata : inst_wdata;
      inst_addr_ok = accept & ~owner;
      data_addr_ok = accept & owner;
      inst_data_ok = rsp_valid & ~rsp_tag;
      data_data_ok = rsp_valid & rsp_tag;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
    end
  end

  assign outstanding = count_q;
  assign err_rsp     = err_q;

  // Grant FSM, in-order tag FIFO, outstanding count and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b0;
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req_int && !mem_addr_ok) begin
            state_q <= HOLD;
            grant_q <= sel;
          end
        end
        HOLD: begin
          // While the FIFO is full req_int is low, so the grant is kept.
          if (accept) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        tag_q[tail_q] <= owner;
        tail_q        <= ptr_next(tail_q);
        last_q        <= owner;
      end

      if (rsp_valid) begin
        head_q <= ptr_next(head_q);
      end

      case ({accept, rsp_valid})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase

      // A response with nothing in flight has no owner; flag it and drop it.
      if (mem_data_ok && (count_q == 3'd0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: instance a uses defaults (MAX_OUT=2, fixed
// data priority), instance b uses round-robin. Both share the same inputs.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok;
  logic [31:0] a_inst_rdata, a_data_rdata;
  logic        a_mem_req, a_mem_wr, a_err_rsp;
  logic [1:0]  a_mem_size;
  logic [3:0]  a_mem_wstrb;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [2:0]  a_outstanding;

  logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok;
  logic [31:0] b_inst_rdata, b_data_rdata;
  logic        b_mem_req, b_mem_wr, b_err_rsp;
  logic [1:0]  b_mem_size;
  logic [3:0]  b_mem_wstrb;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [2:0]  b_outstanding;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h8000_1000;

  sram_port_arbiter #(.MAX_OUT(2), .DATA_PRIO(1)) dut_a (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(a_inst_addr_ok), .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
    .mem_req(a_mem_req), .mem_wr(a_mem_wr), .mem_size(a_mem_size), .mem_wstrb(a_mem_wstrb),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(a_outstanding), .err_rsp(a_err_rsp)
  );

  sram_port_arbiter #(.MAX_OUT(2), .DATA_PRIO(0)) dut_b (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(b_inst_addr_ok), .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
    .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_size(b_mem_size), .mem_wstrb(b_mem_wstrb),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(b_outstanding), .err_rsp(b_err_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = IA; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = DA; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic ireq, dreq, aok;
    logic exp_req, exp_iok, exp_dok;
    logic chk_addr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vt[8];

  // random-phase reference model state
  int q[$];
  bit m_hold, m_grant, m_err, ipend, dpend;

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, IA};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, IA};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DA};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, DA};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, DA};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DA};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    // outputs forced low while rst is high
    rst = 1'b1;
    clear_inputs();
    inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hdead_beef;
    @(negedge clk);
    chk("rst_mem_req", a_mem_req, 0);
    chk("rst_iaok", a_inst_addr_ok, 0);
    chk("rst_idok", a_inst_data_ok, 0);
    chk("rst_irdata", a_inst_rdata, 0);
    chk("rst_maddr", a_mem_addr, 0);
    chk("rst_b_mem_req", b_mem_req, 0);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("rst_outstanding", a_outstanding, 0);
    chk("rst_err", a_err_rsp, 0);
    tick();
    rst = 1'b0;

    // IDLE selection table, each vector from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      inst_req = vt[i].ireq; data_req = vt[i].dreq; mem_addr_ok = vt[i].aok;
      @(negedge clk);
      chk($sformatf("vec%0d_a_req", i), a_mem_req, vt[i].exp_req);
      chk($sformatf("vec%0d_a_iok", i), a_inst_addr_ok, vt[i].exp_iok);
      chk($sformatf("vec%0d_a_dok", i), a_data_addr_ok, vt[i].exp_dok);
      chk($sformatf("vec%0d_b_req", i), b_mem_req, vt[i].exp_req);
      chk($sformatf("vec%0d_b_dok", i), b_data_addr_ok, vt[i].exp_dok);
      if (vt[i].chk_addr) begin
        chk($sformatf("vec%0d_a_addr", i), a_mem_addr, vt[i].exp_addr);
        chk($sformatf("vec%0d_b_addr", i), b_mem_addr, vt[i].exp_addr);
      end
    end

    // single inst read
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("s1_iaok", a_inst_addr_ok, 1);
    chk("s1_maddr", a_mem_addr, IA);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    chk("s1_out1", a_outstanding, 1);
    chk("s1_idok_early", a_inst_data_ok, 0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("s1_idok", a_inst_data_ok, 1);
    chk("s1_irdata", a_inst_rdata, 32'h1234_5678);
    chk("s1_ddok", a_data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    @(negedge clk);
    chk("s1_out0", a_outstanding, 0);

    // fixed priority tie, then in-order responses
    do_reset();
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("s2_maddr", a_mem_addr, DA);
    chk("s2_daok", a_data_addr_ok, 1);
    chk("s2_iaok0", a_inst_addr_ok, 0);
    tick();
    data_req = 0;
    @(negedge clk);
    chk("s2_iaok1", a_inst_addr_ok, 1);
    chk("s2_maddr_i", a_mem_addr, IA);
    chk("s2_out1", a_outstanding, 1);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("s2_rsp1_d", a_data_data_ok, 1);
    chk("s2_rsp1_i", a_inst_data_ok, 0);
    chk("s2_out2", a_outstanding, 2);
    tick();
    @(negedge clk);
    chk("s2_rsp2_i", a_inst_data_ok, 1);
    chk("s2_rsp2_d", a_data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    @(negedge clk);
    chk("s2_out0", a_outstanding, 0);

    // round robin alternation on instance b
    do_reset();
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_b_daok", k), b_data_addr_ok, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_b_iaok", k), b_inst_addr_ok, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d_a_daok", k), a_data_addr_ok, 1);
      tick();
      mem_data_ok = 1;
    end
    clear_inputs();

    // HOLD: data waits three cycles for addr_ok while inst requests
    do_reset();
    data_req = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("h%0d_maddr", k), a_mem_addr, DA);
      chk($sformatf("h%0d_mreq", k), a_mem_req, 1);
      chk($sformatf("h%0d_iaok", k), a_inst_addr_ok, 0);
      chk($sformatf("h%0d_b_maddr", k), b_mem_addr, DA);
      tick();
      inst_req = 1;
    end
    mem_addr_ok = 1;
    @(negedge clk);
    chk("h3_daok", a_data_addr_ok, 1);
    chk("h3_iaok", a_inst_addr_ok, 0);
    chk("h3_b_daok", b_data_addr_ok, 1);
    tick();
    data_req = 0;
    @(negedge clk);
    chk("h4_iaok", a_inst_addr_ok, 1);
    clear_inputs();

    // FIFO full with MAX_OUT=2
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("f0_iaok", a_inst_addr_ok, 1);
    tick();
    inst_req = 0; data_req = 1;
    @(negedge clk);
    chk("f1_daok", a_data_addr_ok, 1);
    tick();
    data_req = 0; inst_req = 1;
    @(negedge clk);
    chk("f2_mreq", a_mem_req, 0);
    chk("f2_iaok", a_inst_addr_ok, 0);
    chk("f2_out", a_outstanding, 2);
    tick();
    mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("f3_idok", a_inst_data_ok, 1);
    chk("f3_ddok", a_data_data_ok, 0);
    chk("f3_mreq", a_mem_req, 0);
    tick();
    @(negedge clk);
    chk("f4_ddok", a_data_data_ok, 1);
    chk("f4_idok", a_inst_data_ok, 0);
    chk("f4_mreq", a_mem_req, 1);
    chk("f4_out", a_outstanding, 1);
    tick();
    mem_data_ok = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("f5_iaok", a_inst_addr_ok, 1);
    tick();
    clear_inputs();

    // spurious response, sticky error, reset mid-transaction
    do_reset();
    mem_data_ok = 1;
    @(negedge clk);
    chk("e0_idok", a_inst_data_ok, 0);
    chk("e0_ddok", a_data_data_ok, 0);
    chk("e0_err", a_err_rsp, 0);
    tick();
    mem_data_ok = 0;
    @(negedge clk);
    chk("e1_err", a_err_rsp, 1);
    inst_req = 1; mem_addr_ok = 1;
    tick();
    tick();
    clear_inputs();
    @(negedge clk);
    chk("e2_err_sticky", a_err_rsp, 1);
    chk("e2_out", a_outstanding, 2);
    do_reset();
    @(negedge clk);
    chk("e3_out_rst", a_outstanding, 0);
    chk("e3_err_rst", a_err_rsp, 0);
    tick();
    mem_data_ok = 1;
    @(negedge clk);
    chk("e4_idok", a_inst_data_ok, 0);
    tick();
    mem_data_ok = 0;
    @(negedge clk);
    chk("e4_err", a_err_rsp, 1);

    // randomized traffic against a queue-based model of instance a
    do_reset();
    q.delete();
    m_hold = 0; m_grant = 0; m_err = 0; ipend = 0; dpend = 0;
    for (int c = 0; c < 3000; c++) begin
      bit own, oreq, ereq, rsp, eidok, eddok;
      int sz;
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1;
        inst_addr = $urandom; inst_wdata = $urandom; inst_wr = 1'($urandom_range(0, 1));
        inst_size = 2'($urandom_range(0, 2)); inst_wstrb = 4'($urandom);
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1;
        data_addr = $urandom; data_wdata = $urandom; data_wr = 1'($urandom_range(0, 1));
        data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
      end
      inst_req = ipend; data_req = dpend;
      mem_addr_ok = 1'($urandom_range(0, 1));
      if (q.size() != 0) mem_data_ok = ($urandom_range(0, 2) == 0);
      else mem_data_ok = ($urandom_range(0, 199) == 0);
      mem_rdata = $urandom;
      @(negedge clk);

      if (m_hold) own = m_grant;
      else if (inst_req && !data_req) own = 0;
      else own = data_req;
      oreq = own ? data_req : inst_req;
      sz = q.size();
      ereq = oreq && (sz < 2);
      rsp = mem_data_ok && (sz != 0);
      eidok = 0; eddok = 0;
      if (rsp) begin
        eidok = (q[0] == 0);
        eddok = (q[0] == 1);
      end
      chk("rnd_mreq", a_mem_req, ereq);
      chk("rnd_iaok", a_inst_addr_ok, ereq && mem_addr_ok && !own);
      chk("rnd_daok", a_data_addr_ok, ereq && mem_addr_ok && own);
      chk("rnd_idok", a_inst_data_ok, eidok);
      chk("rnd_ddok", a_data_data_ok, eddok);
      chk("rnd_irdata", a_inst_rdata, mem_rdata);
      chk("rnd_drdata", a_data_rdata, mem_rdata);
      chk("rnd_out", a_outstanding, sz);
      chk("rnd_err", a_err_rsp, m_err);
      if (ereq) begin
        chk("rnd_maddr", a_mem_addr, own ? data_addr : inst_addr);
        chk("rnd_mwdata", a_mem_wdata, own ? data_wdata : inst_wdata);
        chk("rnd_mctl", {a_mem_wr, a_mem_size, a_mem_wstrb},
            own ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
      end

      if (mem_data_ok && sz == 0) m_err = 1;
      if (rsp) void'(q.pop_front());
      if (ereq && mem_addr_ok) begin
        q.push_back(int'(own));
        m_hold = 0;
        if (own) dpend = 0;
        else ipend = 0;
      end else if (ereq && !m_hold) begin
        m_hold = 1;
        m_grant = own;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
